// File: rtl/random_number_generator.sv
// rtl/random_number_generator.sv - 16-bit Fibonacci LFSR with registered Bernoulli output (P = prob/16)
module random_number_generator (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] seed,
    input  logic [3:0]  prob,
    output logic        out
);

    logic [15:0] state;
    logic        fb;
    logic [15:0] seed_safe;

    // Taps for x^16+x^14+x^13+x^11+1 in right-shifting form
    assign fb        = state[0] ^ state[2] ^ state[3] ^ state[5];
    // An all-zero seed would lock the LFSR, so it is replaced by 1
    assign seed_safe = (seed == 16'h0000) ? 16'h0001 : seed;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= seed_safe;
            out   <= 1'b0;
        end else begin
            out   <= (state[15:12] < prob);
            state <= {fb, state[15:1]};
        end
    end

endmodule

// File: tb/tb_random_number_generator.sv
// tb/tb_random_number_generator.sv - randomized self-checking bench against a behavioural LFSR/Bernoulli model
module tb_random_number_generator;

    logic        clk;
    logic        rst;
    logic [15:0] seed;
    logic [3:0]  prob;
    logic        out;

    int total;
    int bad;
    bit check_en;

    int unsigned m_s;
    bit          exp_out;

    random_number_generator dut (
        .clk  (clk),
        .rst  (rst),
        .seed (seed),
        .prob (prob),
        .out  (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int unsigned model_next(input int unsigned s);
        int unsigned b;
        b = (s ^ (s >> 2) ^ (s >> 3) ^ (s >> 5)) & 1;
        return (s >> 1) + b * 32768;
    endfunction

    function automatic bit model_out(input int unsigned s, input int unsigned p);
        return (s / 4096) < p;
    endfunction

    function automatic int unsigned model_period_count(input int unsigned s0, input int unsigned p);
        int unsigned s;
        int unsigned c;
        s = s0;
        c = 0;
        for (int i = 0; i < 65535; i++) begin
            c = c + model_out(s, p);
            s = model_next(s);
        end
        return c;
    endfunction

    function automatic bit model_nth_out(input int unsigned s0, input int unsigned p, input int n);
        int unsigned s;
        s = s0;
        for (int i = 1; i < n; i++) s = model_next(s);
        return model_out(s, p);
    endfunction

    // Reference: reloads on reset, otherwise one compare and one shift per edge
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_s     = (seed == 16'h0000) ? 1 : seed;
            exp_out = 1'b0;
        end else begin
            exp_out = model_out(m_s, prob);
            m_s     = model_next(m_s);
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            total++;
            if (out !== exp_out) begin
                bad++;
                $display("FAIL out_cycle t=%0t got=%b want=%b", $time, out, exp_out);
            end
            total++;
            if (dut.state !== m_s[15:0]) begin
                bad++;
                $display("FAIL state_cycle t=%0t got=%h want=%h", $time, dut.state, m_s[15:0]);
            end
        end
    end

    task automatic check(input string name, input int unsigned got, input int unsigned want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset(input logic [15:0] s);
        seed = s;
        rst  = 1'b1;
        step();
        rst  = 1'b0;
    endtask

    initial begin
        int unsigned ones;
        int          ret_edge;
        bit          seen_one;
        total    = 0;
        bad      = 0;
        check_en = 1'b0;
        seed     = 16'h0001;
        prob     = 4'd2;
        rst      = 1'b1;
        #12;

        // Model pins
        check("pin_next_0001", model_next(16'h0001), 16'h8000);
        check("pin_next_8000", model_next(16'h8000), 16'h4000);
        check("pin_cnt_p8", model_period_count(16'hACE1, 8), 32767);
        check("pin_cnt_p15", model_period_count(16'hACE1, 15), 61439);
        check("pin_cnt_p0", model_period_count(16'hACE1, 0), 0);

        check("reset_out", out, 0);
        check("reset_state", dut.state, 16'h0001);
        check_en = 1'b1;

        // Literal first edges from seed 1, prob 2
        do_reset(16'h0001);
        step();
        check("edge1_out", out, 1);
        check("edge1_state", dut.state, 16'h8000);
        step();
        check("edge2_out", out, 0);

        // Seed 0 behaves like seed 1
        prob = 4'd7;
        do_reset(16'h0000);
        check("seed0_state", dut.state, 16'h0001);
        for (int n = 1; n <= 20; n++) begin
            step();
            check($sformatf("seed0_out%0d", n), out, model_nth_out(16'h0001, 7, n));
        end

        // prob = 0 for 1000 cycles
        prob = 4'd0;
        ones = 0;
        for (int i = 0; i < 1000; i++) begin
            step();
            ones += out;
        end
        check("prob0_ones", ones, 0);

        // Switch 0 -> 15 at a known edge
        prob = 4'd15;
        for (int i = 0; i < 40; i++) step();

        // Asynchronous reset between edges
        seed_one_search: begin
            seen_one = 1'b0;
            for (int i = 0; i < 64 && !seen_one; i++) begin
                step();
                seen_one = out;
            end
            check("async_prep_one", seen_one, 1);
        end
        seed = 16'h1234;
        #1;
        rst = 1'b1;
        #1;
        check("async_rst_out", out, 0);
        check("async_rst_state", dut.state, 16'h1234);
        step();
        rst = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            step();
            check($sformatf("after_rst_out%0d", n), out, model_nth_out(16'h1234, 15, n));
        end

        // Randomized prob with occasional random-seed resets
        for (int i = 0; i < 3000; i++) begin
            prob = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 199) == 0) begin
                do_reset(16'($urandom));
            end else begin
                step();
            end
        end

        // Full period at prob 2 from 16'hACE1
        prob     = 4'd2;
        do_reset(16'hACE1);
        ones     = 0;
        ret_edge = 0;
        for (int e = 1; e <= 65535; e++) begin
            step();
            ones += out;
            if (ret_edge == 0 && dut.state == 16'hACE1) ret_edge = e;
        end
        check("period_return_edge", ret_edge, 65535);
        check("period_ones_p2", ones, 8191);

        check_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/random_number_generator.md
Name: random_number_generator

Overview:
- Free-running 16-bit maximal-length LFSR pseudo-random generator with a Bernoulli output.
- Each clock, `out` is 1 with probability prob/16.
- Used as a stochastic spike/event source: one generator per consumer, seeded individually.
- The long-run fraction of `out`=1 cycles is prob/16.

Parameters:
- None. State width is fixed at 16 bits; probability width is fixed at 4 bits.

Ports:
- clk   input   1   system clock; all state updates on rising edge
- rst   input   1   reset, asynchronous, active-high; loads seed into LFSR, clears out
- seed  input   16  initial LFSR state; sampled only while rst is high
- prob  input   4   probability numerator, in sixteenths (0..15); sampled every cycle
- out   output  1   registered Bernoulli output

Behaviour:
- State register S[15:0]: Fibonacci LFSR, polynomial x^16+x^14+x^13+x^11+1, right-shifting.
  - fb = S[0]^S[2]^S[3]^S[5]
  - S_next = {fb, S[15:1]}
  - Period is 65535 and visits every nonzero state exactly once.
- Reset, asynchronous while rst=1:
  - S <= seed; if seed==16'h0000 then S <= 16'h0001 (lock-up guard; all-zero state is never entered).
  - out <= 0.
- Each rising clk edge with rst=0:
  - out <= (S[15:12] < prob), unsigned compare using the current (pre-shift) S.
  - S <= S_next.
- Latency: `out` at edge n reflects the state held before edge n. The first edge after reset release uses the seed itself.
- prob=0: out stays 0 forever.
- prob=15: out=0 only when S[15:12]==4'hF.
- Over any full period of 65535 consecutive clocks, the count of out=1 is prob*4096 - 1 for prob>=1, and 0 for prob=0. The "-1" is because state 0 is absent.
- prob changes take effect on the next edge; there is no internal buffering of prob.
- Reset asserted mid-operation: S is immediately reloaded from seed and out forced to 0, regardless of the clock. Sequence restarts deterministically after release.
- seed changes while rst=0 are ignored.
- No enable input; the generator advances every cycle.

Test Plan:
- seed=16'h0001, prob=2, release reset:
  - edge1: out=1 (S=0001, top nibble 0); S becomes 16'h8000.
  - edge2: out=0 (top nibble 8).
- seed=16'h0000, reset then release: behaves identically to seed=16'h0001 (same out sequence for 20 cycles).
- Period and ratio check, seed=16'hACE1, prob=2: run 65535 edges.
  - S returns to 16'hACE1 exactly at edge 65535 and not before.
  - Count of out=1 equals 8191.
  - Repeat with prob=8: count=32767.
- prob=0 for 1000 cycles -> out never 1. prob=15 over a full period -> out=1 count equals 61439.
- Reset asserted asynchronously between clock edges mid-run -> out drops to 0 without waiting for a clock edge; after release, the sequence matches a fresh run from the same seed.
- prob switched from 0 to 15 at a known edge -> the out response follows the compare rule starting the next edge; checked against a reference LFSR model cycle by cycle.
